window_3x3_gen: RTL and testbench

WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

---
 rtl/window_3x3_gen.sv | 208 ++++++++++++++++++++
 tb/tb_window_3x3_gen.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/window_3x3_gen.sv
// Raster-stream 3x3 neighbourhood generator: two line buffers feed a shifting 3x3 array, one window per pixel.
// Out-of-image taps read 0; define WINDOW_EDGE_REPLICATE_EN to clamp them to the nearest edge pixel instead.
module window_3x3_gen #(
   parameter int unsigned COLS = 512,
   parameter int unsigned ROWS = 512
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [7:0]           in_pixel,
   output logic                 win_valid,
   input  logic                 win_ready,
   output logic [2:0][2:0][7:0] out_window,
   output logic                 busy,
   output logic                 frame_done
);
   localparam int unsigned NPIX  = ROWS * COLS;
   localparam int unsigned DLY   = COLS + 1;
   localparam int unsigned CNT_W = $clog2(NPIX + 1);
   localparam int unsigned CW    = $clog2(COLS);
   localparam int unsigned RW    = $clog2(ROWS);

   typedef enum logic [2:0] {IDLE, FILL, STREAM, FLUSH, DONE} state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     in_cnt_q, in_cnt_d;
   logic [CNT_W-1:0]     prod_cnt_q, prod_cnt_d;
   logic [CNT_W-1:0]     out_cnt_q, out_cnt_d;
   logic [CW-1:0]        wr_col_q, wr_col_d;
   logic [CW-1:0]        ctr_col_q, ctr_col_d;
   logic [RW-1:0]        ctr_row_q, ctr_row_d;
   logic                 win_valid_q, win_valid_d;
   logic                 busy_q, busy_d;
   logic                 frame_done_q, frame_done_d;
   logic [2:0][2:0][7:0] raw_q, raw_d;
   logic [2:0][2:0][7:0] out_window_q, out_window_d;
   logic [2:0][2:0][7:0] shifted, shaped;
   logic [7:0]           lb1_mem [COLS];
   logic [7:0]           lb2_mem [COLS];
   logic [7:0]           lb1_rd, lb2_rd, new_pix;
   logic                 slot_free, out_hs, accept, produce, shift;
   logic                 top_edge, bot_edge, lft_edge, rgt_edge;

   assign slot_free = !win_valid_q || win_ready;
   assign out_hs    = win_valid_q && win_ready;
   assign shift     = accept || produce;

   // Frame sequencing: fill the first D pixels, stream one-in/one-out, then drain D windows.
   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      accept   = 1'b0;
      produce  = 1'b0;
      new_pix  = in_pixel;
      case (state_q)
         IDLE: begin
            if (start) state_d = FILL;
         end
         FILL: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept = 1'b1;
               if (in_cnt_q == CNT_W'(DLY - 1)) state_d = STREAM;
            end
         end
         STREAM: begin
            in_ready = slot_free;
            if (in_valid && slot_free) begin
               accept  = 1'b1;
               produce = 1'b1;
               if (in_cnt_q == CNT_W'(NPIX - 1)) state_d = FLUSH;
            end
         end
         FLUSH: begin
            new_pix = '0;
            if (slot_free && (prod_cnt_q != CNT_W'(NPIX))) produce = 1'b1;
            if (out_hs && (out_cnt_q == CNT_W'(NPIX - 1))) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Counters; ctr_row/ctr_col track the centre of the window produced next.
   always_comb begin
      in_cnt_d   = in_cnt_q;
      prod_cnt_d = prod_cnt_q;
      out_cnt_d  = out_cnt_q;
      wr_col_d   = wr_col_q;
      ctr_col_d  = ctr_col_q;
      ctr_row_d  = ctr_row_q;
      if ((state_q == IDLE) && start) begin
         in_cnt_d   = '0;
         prod_cnt_d = '0;
         out_cnt_d  = '0;
         wr_col_d   = '0;
         ctr_col_d  = '0;
         ctr_row_d  = '0;
      end else begin
         if (accept) in_cnt_d = in_cnt_q + CNT_W'(1);
         if (out_hs) out_cnt_d = out_cnt_q + CNT_W'(1);
         if (shift) wr_col_d = (wr_col_q == CW'(COLS - 1)) ? '0 : wr_col_q + CW'(1);
         if (produce) begin
            prod_cnt_d = prod_cnt_q + CNT_W'(1);
            if (ctr_col_q == CW'(COLS - 1)) begin
               ctr_col_d = '0;
               ctr_row_d = ctr_row_q + RW'(1);
            end else begin
               ctr_col_d = ctr_col_q + CW'(1);
            end
         end
      end
      win_valid_d  = produce || (win_valid_q && !win_ready);
      busy_d       = (state_d == FILL) || (state_d == STREAM) || (state_d == FLUSH);
      frame_done_d = (state_d == DONE);
   end

   assign lb1_rd   = lb1_mem[wr_col_q];
   assign lb2_rd   = lb2_mem[wr_col_q];
   assign top_edge = (ctr_row_q == '0);
   assign bot_edge = (ctr_row_q == RW'(ROWS - 1));
   assign lft_edge = (ctr_col_q == '0);
   assign rgt_edge = (ctr_col_q == CW'(COLS - 1));

   // Raw window wraps across rows and holds stale taps; edge shaping hides both.
   always_comb begin
      shifted = raw_q;
      for (int i = 0; i < 3; i++) begin
         shifted[i][0] = raw_q[i][1];
         shifted[i][1] = raw_q[i][2];
      end
      shifted[0][2] = lb2_rd;
      shifted[1][2] = lb1_rd;
      shifted[2][2] = new_pix;

      shaped = shifted;
`ifdef WINDOW_EDGE_REPLICATE_EN
      for (int i = 0; i < 3; i++) begin
         if (lft_edge) shaped[i][0] = shaped[i][1];
         if (rgt_edge) shaped[i][2] = shaped[i][1];
      end
      for (int j = 0; j < 3; j++) begin
         if (top_edge) shaped[0][j] = shaped[1][j];
         if (bot_edge) shaped[2][j] = shaped[1][j];
      end
`else
      for (int i = 0; i < 3; i++) begin
         if (lft_edge) shaped[i][0] = '0;
         if (rgt_edge) shaped[i][2] = '0;
      end
      for (int j = 0; j < 3; j++) begin
         if (top_edge) shaped[0][j] = '0;
         if (bot_edge) shaped[2][j] = '0;
      end
`endif
      raw_d        = shift ? shifted : raw_q;
      out_window_d = produce ? shaped : out_window_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         in_cnt_q     <= '0;
         prod_cnt_q   <= '0;
         out_cnt_q    <= '0;
         wr_col_q     <= '0;
         ctr_col_q    <= '0;
         ctr_row_q    <= '0;
         win_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         raw_q        <= '0;
         out_window_q <= '0;
      end else begin
         state_q      <= state_d;
         in_cnt_q     <= in_cnt_d;
         prod_cnt_q   <= prod_cnt_d;
         out_cnt_q    <= out_cnt_d;
         wr_col_q     <= wr_col_d;
         ctr_col_q    <= ctr_col_d;
         ctr_row_q    <= ctr_row_d;
         win_valid_q  <= win_valid_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         raw_q        <= raw_d;
         out_window_q <= out_window_d;
      end
   end

   // Line buffers cascade one row per COLS shifts; contents need no reset.
   always_ff @(posedge clk) begin
      if (shift) begin
         lb1_mem[wr_col_q] <= new_pix;
         lb2_mem[wr_col_q] <= lb1_mem[wr_col_q];
      end
   end

   assign win_valid  = win_valid_q;
   assign out_window = out_window_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen on a 4x4 image; expected windows are queued as pixels are accepted.
module tb_window_3x3_gen;
   localparam int TC = 4;
   localparam int TR = 4;
   localparam int NP = TC * TR;
   localparam int DL = TC + 1;

   typedef logic [2:0][2:0][7:0] win_t;

   logic       clk = 1'b0;
   logic       reset, start, in_valid, in_ready, win_valid, win_ready, busy, frame_done;
   logic [7:0] in_pixel;
   win_t       out_window;

   win_t       exp_q[$];
   win_t       got [NP];
   logic [7:0] pix [NP];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         win_idx = 0;
   int         fd_cnt = 0;
   int         last_hs_cyc = -10;
   logic       acc_s = 1'b0;
   logic       prev_fd = 1'b0;
   logic       pulse_on_done = 1'b0;
   logic       started_in_done = 1'b0;

   always #5 clk = ~clk;

   window_3x3_gen #(.COLS(TC), .ROWS(TR)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_pixel   (in_pixel),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .out_window (out_window),
      .busy       (busy),
      .frame_done (frame_done)
   );

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic win_t mk(input int a0, input int a1, input int a2,
                               input int a3, input int a4, input int a5,
                               input int a6, input int a7, input int a8);
      win_t w;
      w[0][0] = 8'(a0); w[0][1] = 8'(a1); w[0][2] = 8'(a2);
      w[1][0] = 8'(a3); w[1][1] = 8'(a4); w[1][2] = 8'(a5);
      w[2][0] = 8'(a6); w[2][1] = 8'(a7); w[2][2] = 8'(a8);
      return w;
   endfunction

   function automatic win_t exp_win(input int m);
      win_t w;
      int   r, c, rr, cc;
      w = '0;
      r = m / TC;
      c = m % TC;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            rr = r - 1 + i;
            cc = c - 1 + j;
`ifdef WINDOW_EDGE_REPLICATE_EN
            if (rr < 0) rr = 0;
            if (rr > TR - 1) rr = TR - 1;
            if (cc < 0) cc = 0;
            if (cc > TC - 1) cc = TC - 1;
            w[i][j] = pix[rr * TC + cc];
`else
            if (rr < 0 || rr >= TR || cc < 0 || cc >= TC) w[i][j] = 8'h00;
            else w[i][j] = pix[rr * TC + cc];
`endif
         end
      end
      return w;
   endfunction

   task automatic set_frame(input int sel);
      for (int k = 0; k < NP; k++) pix[k] = (sel == 0) ? 8'(k + 1) : 8'(200 - 11 * k);
   endtask

   // One clock: sample/score at negedge, return 1 time unit after the next posedge.
   task automatic tick();
      @(negedge clk);
      acc_s = in_valid && in_ready;
      if (win_valid && win_ready) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL win_extra: observed window %0h, expected none pending", out_window);
         end
         if (exp_q.size() != 0) chk("window", out_window, exp_q.pop_front());
         if (win_idx < NP) got[win_idx] = out_window;
         win_idx++;
         last_hs_cyc = cyc;
      end
      if (frame_done) begin
         fd_cnt++;
         chk("fd_timing", 72'(cyc), 72'(last_hs_cyc + 1));
         chk("fd_busy", 72'(busy), 72'(0));
         chk("fd_width", 72'(prev_fd), 72'(0));
         if (pulse_on_done) begin
            start = 1'b1;
            started_in_done = 1'b1;
         end
      end
      prev_fd = frame_done;
      @(posedge clk);
      #1;
      cyc++;
      if (started_in_done) begin
         start = 1'b0;
         started_in_done = 1'b0;
         pulse_on_done = 1'b0;
      end
   endtask

   task automatic send_pixel(input int k, input int bp_cycles, input logic pulse_start);
      int   n;
      win_t held;
      n = 0;
      in_valid = 1'b1;
      in_pixel = pix[k];
      if (bp_cycles > 0) begin
         win_ready = 1'b0;
         held = out_window;
         for (int b = 0; b < bp_cycles; b++) begin
            tick();
            chk("bp_no_accept", 72'(acc_s), 72'(0));
            chk("bp_in_ready", 72'(in_ready), 72'(0));
            chk("bp_valid", 72'(win_valid), 72'(1));
            chk("bp_stable", out_window, held);
         end
         win_ready = 1'b1;
      end
      start = pulse_start;
      do begin
         tick();
         n++;
      end while (!acc_s && n < 100);
      start = 1'b0;
      chk("in_accept", 72'(acc_s), 72'(1));
      if (k >= DL) exp_q.push_back(exp_win(k - DL));
   endtask

   task automatic run_frame(input int bp_at, input int start_at, input logic pulse_done);
      int base_fd;
      int n;
      base_fd = fd_cnt;
      n = 0;
      win_idx = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_fill", 72'(busy), 72'(1));
      for (int k = 0; k < NP; k++) begin
         send_pixel(k, (k == bp_at) ? 10 : 0, (k == start_at));
         if (k == DL - 1) chk("win_valid_pre", 72'(win_valid), 72'(0));
         if (k == DL) chk("win_valid_first", 72'(win_valid), 72'(1));
      end
      in_valid = 1'b0;
      for (int m = NP - DL; m < NP; m++) exp_q.push_back(exp_win(m));
      pulse_on_done = pulse_done;
      while (fd_cnt == base_fd && n < 300) begin
         tick();
         n++;
      end
      chk("frame_done_seen", 72'(fd_cnt - base_fd), 72'(1));
      tick();
      tick();
      chk("idle_busy", 72'(busy), 72'(0));
      chk("idle_in_ready", 72'(in_ready), 72'(0));
      chk("frame_done_once", 72'(fd_cnt - base_fd), 72'(1));
      chk("win_count", 72'(win_idx), 72'(NP));
      chk("queue_empty", 72'(exp_q.size()), 72'(0));
   endtask

   task automatic check_literals();
`ifdef WINDOW_EDGE_REPLICATE_EN
      chk("first_win", got[0], mk(1, 1, 2, 1, 1, 2, 5, 5, 6));
      chk("last_win", got[15], mk(11, 12, 12, 15, 16, 16, 15, 16, 16));
`else
      chk("first_win", got[0], mk(0, 0, 0, 0, 1, 2, 0, 5, 6));
      chk("last_win", got[15], mk(11, 12, 0, 15, 16, 0, 0, 0, 0));
`endif
      chk("centre_1_1", got[5], mk(1, 2, 3, 5, 6, 7, 9, 10, 11));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, 72'(in_ready), 72'(0));
      chk({tag, "_win_valid"}, 72'(win_valid), 72'(0));
      chk({tag, "_busy"}, 72'(busy), 72'(0));
      chk({tag, "_frame_done"}, 72'(frame_done), 72'(0));
      chk({tag, "_out_window"}, out_window, 72'(0));
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      in_valid  = 1'b0;
      in_pixel  = 8'h00;
      win_ready = 1'b1;
      set_frame(0);
      repeat (3) tick();
      check_reset_outputs("reset");
      reset = 1'b0;

      // Frame with ignored start pulses during STREAM and in DONE
      run_frame(-1, 7, 1'b1);
      check_literals();

      // Frame with a 10-cycle output stall mid-stream
      run_frame(9, -1, 1'b0);
      check_literals();

      // Reset after 8 accepted pixels
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 8; k++) send_pixel(k, 0, 1'b0);
      in_valid = 1'b0;
      reset = 1'b1;
      tick();
      check_reset_outputs("midreset");
      exp_q.delete();
      reset = 1'b0;

      // Different pixel data straight after reset, then the reference frame again
      set_frame(1);
      run_frame(-1, -1, 1'b0);
      set_frame(0);
      run_frame(-1, -1, 1'b0);
      check_literals();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
